// File: rtl/lsu_ctrl_pkg.sv
// lsu_ctrl_pkg: shared definitions for the load/store controller.
//   - DEFAULT_BUS_WIDTH : default data/address width
//   - SZ_*              : access size encodings (shared by req_size/mem_size)
//   - lsu_state_e       : controller FSM state encoding (IDLE/ACCESS/RESP)
//   - cnt_reload()      : wait-counter reload value for a given memory latency
// Build option: LSU_MISALIGN_TRAP_EN (see lsu_align_check).
package lsu_ctrl_pkg;

  localparam int DEFAULT_BUS_WIDTH = 32;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } lsu_state_e;

  // The counter is loaded with latency-1 so that ACCESS lasts exactly
  // `lat` cycles (the cycle in which it reads 0 is the last one).
  function automatic logic [2:0] cnt_reload(input int lat);
    return 3'(lat - 1);
  endfunction

endpackage

// File: rtl/lsu_align_check.sv
// lsu_align_check: combinational size/alignment classifier for one request.
// Ports:
//   size_i         in   access size (SZ_* encoding)
//   addr_i         in   requested byte address
//   misaligned_o   out  request must be rejected for misalignment
//   illegal_o      out  size encoding is illegal (2'b11)
//   aligned_addr_o out  address to drive on the memory port
// Build option LSU_MISALIGN_TRAP_EN:
//   defined   -> misaligned half/word accesses are flagged for rejection and
//                the address passes through unchanged.
//   undefined -> misaligned_o is never set; the low address bits are cleared
//                so the access proceeds at the aligned address.
module lsu_align_check
  import lsu_ctrl_pkg::*;
#(
  parameter int BUS_WIDTH = DEFAULT_BUS_WIDTH
) (
  input  logic [1:0]           size_i,
  input  logic [BUS_WIDTH-1:0] addr_i,
  output logic                 misaligned_o,
  output logic                 illegal_o,
  output logic [BUS_WIDTH-1:0] aligned_addr_o
);

  logic raw_misaligned;

  always_comb begin
    raw_misaligned = 1'b0;
    case (size_i)
      SZ_HALF: raw_misaligned = addr_i[0];
      SZ_WORD: raw_misaligned = |addr_i[1:0];
      default: raw_misaligned = 1'b0;
    endcase
  end

  assign illegal_o = (size_i == SZ_ILLEGAL);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned_o   = raw_misaligned;
  assign aligned_addr_o = addr_i;
`else
  assign misaligned_o = 1'b0;

  always_comb begin
    aligned_addr_o = addr_i;
    if (raw_misaligned) begin
      if (size_i == SZ_HALF) aligned_addr_o[0]   = 1'b0;
      else                   aligned_addr_o[1:0] = 2'b00;
    end
  end
`endif

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: multi-cycle load/store controller, initiator of the data memory
// port. One request in flight at a time, one response per request.
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   req_valid/req_ready      request handshake
//   req_we, req_size, req_unsigned, req_addr, req_wdata   request fields
//   resp_valid, resp_rdata, resp_err                       response
//   mem_address, mem_data_in, mem_wr_en, mem_size, mem_sz_ex  memory drive
//   mem_data_out             combinational read data from memory
// Build option LSU_MISALIGN_TRAP_EN: reject misaligned half/word accesses
// instead of silently aligning them (see lsu_align_check).
//
// Handshake: a request is taken on a rising edge where req_valid and
// req_ready are both high; req_ready is high only in IDLE, so req_* are
// sampled once and may change freely afterwards. resp_valid is a one-cycle
// strobe with no back-pressure.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int BUS_WIDTH   = DEFAULT_BUS_WIDTH,
  parameter int MEM_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [BUS_WIDTH-1:0] req_addr,
  input  logic [BUS_WIDTH-1:0] req_wdata,
  output logic                 resp_valid,
  output logic [BUS_WIDTH-1:0] resp_rdata,
  output logic                 resp_err,
  output logic [BUS_WIDTH-1:0] mem_address,
  output logic [BUS_WIDTH-1:0] mem_data_in,
  output logic                 mem_wr_en,
  output logic [1:0]           mem_size,
  output logic                 mem_sz_ex,
  input  logic [BUS_WIDTH-1:0] mem_data_out
);

  localparam logic [2:0] CNT_RELOAD = cnt_reload(MEM_LATENCY);

  lsu_state_e           state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic                 we_q, we_d;
  logic                 err_q, err_d;
  logic                 first_q, first_d;
  logic [BUS_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic [BUS_WIDTH-1:0] mem_address_q, mem_address_d;
  logic [BUS_WIDTH-1:0] mem_data_in_q, mem_data_in_d;
  logic [1:0]           mem_size_q, mem_size_d;
  logic                 mem_sz_ex_q, mem_sz_ex_d;

  logic                 ac_misaligned;
  logic                 ac_illegal;
  logic [BUS_WIDTH-1:0] ac_aligned_addr;
  logic                 reject;

  lsu_align_check #(
    .BUS_WIDTH(BUS_WIDTH)
  ) u_align (
    .size_i        (req_size),
    .addr_i        (req_addr),
    .misaligned_o  (ac_misaligned),
    .illegal_o     (ac_illegal),
    .aligned_addr_o(ac_aligned_addr)
  );

  assign reject = ac_illegal | ac_misaligned;

  // ---------------------------------------------------------------- state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      we_q          <= 1'b0;
      err_q         <= 1'b0;
      first_q       <= 1'b0;
      resp_rdata_q  <= '0;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
      mem_size_q    <= SZ_WORD;
      mem_sz_ex_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      we_q          <= we_d;
      err_q         <= err_d;
      first_q       <= first_d;
      resp_rdata_q  <= resp_rdata_d;
      mem_address_q <= mem_address_d;
      mem_data_in_q <= mem_data_in_d;
      mem_size_q    <= mem_size_d;
      mem_sz_ex_q   <= mem_sz_ex_d;
    end
  end

  // ----------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) state_d = reject ? ST_RESP : ST_ACCESS;
      end
      ST_ACCESS: begin
        if (cnt_q == 3'd0) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------- datapath
  always_comb begin
    cnt_d         = cnt_q;
    we_d          = we_q;
    err_d         = err_q;
    first_d       = first_q;
    resp_rdata_d  = resp_rdata_q;
    mem_address_d = mem_address_q;
    mem_data_in_d = mem_data_in_q;
    mem_size_d    = mem_size_q;
    mem_sz_ex_d   = mem_sz_ex_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d         = req_we;
          err_d        = reject;
          first_d      = 1'b1;
          cnt_d        = CNT_RELOAD;
          // Cleared here so stores and rejected requests answer with zero.
          resp_rdata_d = '0;
          // A rejected request leaves the memory port untouched.
          if (!reject) begin
            mem_address_d = ac_aligned_addr;
            mem_data_in_d = req_wdata;
            mem_size_d    = req_size;
            mem_sz_ex_d   = ~req_we & ~req_unsigned;
          end
        end
      end
      ST_ACCESS: begin
        first_d = 1'b0;
        if (cnt_q == 3'd0) begin
          if (!we_q) resp_rdata_d = mem_data_out;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------- outputs
  always_comb begin
    req_ready  = (state_q == ST_IDLE);
    resp_valid = (state_q == ST_RESP);
    resp_err   = (state_q == ST_RESP) & err_q;
    // Single-cycle write strobe: only the first ACCESS cycle of a store.
    mem_wr_en  = (state_q == ST_ACCESS) & we_q & first_q;
  end

  assign resp_rdata  = resp_rdata_q;
  assign mem_address = mem_address_q;
  assign mem_data_in = mem_data_in_q;
  assign mem_size    = mem_size_q;
  assign mem_sz_ex   = mem_sz_ex_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: self-checking bench for lsu_ctrl with a byte-addressed
// memory model on the memory port and an expected-response queue.
module tb_lsu_ctrl;
  localparam int BW  = 32;
  localparam int LAT = 3;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        szex;
    logic        wr;
    logic [31:0] wdata;
    logic [7:0]  acc;
    logic [31:0] stamp;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]    req_size;
  logic [BW-1:0] req_addr, req_wdata;
  logic          resp_valid, resp_err;
  logic [BW-1:0] resp_rdata;
  logic [BW-1:0] mem_address, mem_data_in, mem_data_out;
  logic          mem_wr_en, mem_sz_ex;
  logic [1:0]    mem_size;

  exp_t          exp_q[$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            acc_cnt = 0;
  int            wr_cnt = 0;
  logic [31:0]   snap_addr, snap_wdata;
  logic [1:0]    snap_size;
  logic          snap_szex;
  logic [7:0]    mem_arr[0:63];

  // ------------------------------------------------------ clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lsu_ctrl #(.BUS_WIDTH(BW), .MEM_LATENCY(LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .mem_address (mem_address),
    .mem_data_in (mem_data_in),
    .mem_wr_en   (mem_wr_en),
    .mem_size    (mem_size),
    .mem_sz_ex   (mem_sz_ex),
    .mem_data_out(mem_data_out)
  );

  // ------------------------------------------------------- memory model
  always_comb begin
    int a;
    a = int'(mem_address[5:0]);
    case (mem_size)
      2'b10: mem_data_out = {mem_arr[(a+3)&63], mem_arr[(a+2)&63],
                             mem_arr[(a+1)&63], mem_arr[a]};
      2'b01: mem_data_out = {{16{mem_sz_ex & mem_arr[(a+1)&63][7]}},
                             mem_arr[(a+1)&63], mem_arr[a]};
      2'b00: mem_data_out = {{24{mem_sz_ex & mem_arr[a][7]}}, mem_arr[a]};
      default: mem_data_out = '0;
    endcase
  end

  always @(posedge clk) begin
    int a;
    a = int'(mem_address[5:0]);
    if (mem_wr_en) begin
      mem_arr[a] <= mem_data_in[7:0];
      if (mem_size != 2'b00) mem_arr[(a+1)&63] <= mem_data_in[15:8];
      if (mem_size == 2'b10) begin
        mem_arr[(a+2)&63] <= mem_data_in[23:16];
        mem_arr[(a+3)&63] <= mem_data_in[31:24];
      end
    end
  end

  // ------------------------------------------------------------ checker
  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ------------------------------------------------------------- driver
  task automatic drive_req(input logic we, input logic [1:0] size,
                           input logic uns, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic push,
                           input logic e_err, input logic [31:0] e_rdata,
                           input logic [31:0] e_addr);
    int guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) check_eq("ready_timeout", 0, 1);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    if (push) begin
      e.err   = e_err;
      e.rdata = e_rdata;
      e.addr  = e_addr;
      e.size  = size;
      e.szex  = ~we & ~uns;
      e.wr    = we & ~e_err;
      e.wdata = wdata;
      e.acc   = e_err ? 8'd0 : 8'(LAT);
      e.stamp = 32'(cyc);
      exp_q.push_back(e);
    end
    @(negedge clk);
    req_valid    = 1'b0;
    req_we       = 1'($urandom);
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_addr     = $urandom;
    req_wdata    = $urandom;
  endtask

  // ------------------------------------------------------------ monitor
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      acc_cnt = 0;
      wr_cnt  = 0;
    end else begin
      if (mem_wr_en) wr_cnt++;
      if (!req_ready && !resp_valid) begin
        acc_cnt++;
        snap_addr = mem_address;
        snap_size = mem_size;
        snap_szex = mem_sz_ex;
        if (mem_wr_en) snap_wdata = mem_data_in;
      end
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_resp", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("resp_rdata", resp_rdata, e.rdata);
          check_eq("resp_err", resp_err, e.err);
          check_eq("latency", 64'(cyc) - 64'(e.stamp), 64'(e.acc) + 64'd1);
          check_eq("access_cycles", acc_cnt, e.acc);
          check_eq("wr_pulses", wr_cnt, e.wr);
          if (!e.err) begin
            check_eq("mem_address", snap_addr, e.addr);
            check_eq("mem_size", snap_size, e.size);
            check_eq("mem_sz_ex", snap_szex, e.szex);
          end
          if (e.wr) check_eq("mem_data_in", snap_wdata, e.wdata);
        end
        acc_cnt = 0;
        wr_cnt  = 0;
      end
    end
  end

  // ----------------------------------------------------------- stimulus
  initial begin
    logic [31:0] a, d;
    logic        u;
    for (int i = 0; i < 64; i++) mem_arr[i] = 8'h00;
    req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0;
    req_addr = 0; req_wdata = 0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    check_eq("rst_req_ready", req_ready, 1);
    check_eq("rst_resp_valid", resp_valid, 0);
    check_eq("rst_resp_err", resp_err, 0);
    check_eq("rst_resp_rdata", resp_rdata, 0);
    check_eq("rst_mem_address", mem_address, 0);
    check_eq("rst_mem_data_in", mem_data_in, 0);
    check_eq("rst_mem_wr_en", mem_wr_en, 0);
    check_eq("rst_mem_size", mem_size, 2'b10);
    check_eq("rst_mem_sz_ex", mem_sz_ex, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // store word / signed load word
    drive_req(1, 2'b10, 0, 32'd8, 32'h00FFFFFF, 1, 0, 32'h0, 32'd8);
    drive_req(0, 2'b10, 0, 32'd8, 32'h0, 1, 0, 32'h00FFFFFF, 32'd8);
    // store byte / unsigned half load
    drive_req(1, 2'b00, 0, 32'd4, 32'h0000FFFF, 1, 0, 32'h0, 32'd4);
    drive_req(0, 2'b01, 1, 32'd4, 32'h0, 1, 0, 32'h000000FF, 32'd4);
    // store word / signed byte load
    drive_req(1, 2'b10, 0, 32'd0, 32'h000000FF, 1, 0, 32'h0, 32'd0);
    drive_req(0, 2'b00, 0, 32'd0, 32'h0, 1, 0, 32'hFFFFFFFF, 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
    drive_req(0, 2'b10, 0, 32'd6, 32'h0, 1, 1, 32'h0, 32'd0);
    drive_req(1, 2'b01, 0, 32'd9, 32'h1234, 1, 1, 32'h0, 32'd0);
    drive_req(0, 2'b10, 1, 32'd8, 32'h0, 1, 0, 32'h00FFFFFF, 32'd8);
`else
    drive_req(0, 2'b10, 0, 32'd6, 32'h0, 1, 0, 32'h000000FF, 32'd4);
    drive_req(1, 2'b01, 0, 32'd9, 32'h1234, 1, 0, 32'h0, 32'd8);
    drive_req(0, 2'b10, 1, 32'd8, 32'h0, 1, 0, 32'h00FF1234, 32'd8);
`endif
    // illegal size, store and load
    drive_req(1, 2'b11, 0, 32'd16, 32'hAA, 1, 1, 32'h0, 32'd0);
    drive_req(0, 2'b11, 0, 32'd16, 32'h0, 1, 1, 32'h0, 32'd0);

    // reset during the first ACCESS cycle of a store
    drive_req(1, 2'b10, 0, 32'd12, 32'hDEADBEEF, 0, 0, 32'h0, 32'd0);
    check_eq("abort_wr_pre", mem_wr_en, 1);
    #2 rst = 1'b0;
    #1;
    check_eq("abort_wr_drop", mem_wr_en, 0);
    check_eq("abort_resp_valid", resp_valid, 0);
    check_eq("abort_req_ready", req_ready, 1);
    repeat (2) begin
      @(negedge clk);
      check_eq("abort_no_resp", resp_valid, 0);
    end
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_ready_after", req_ready, 1);
    drive_req(0, 2'b10, 1, 32'd12, 32'h0, 1, 0, 32'h0, 32'd12);
    drive_req(1, 2'b10, 0, 32'd12, 32'hDEADBEEF, 1, 0, 32'h0, 32'd12);
    drive_req(0, 2'b10, 1, 32'd12, 32'h0, 1, 0, 32'hDEADBEEF, 32'd12);

    // random aligned word store/load pairs
    for (int i = 0; i < 6; i++) begin
      a = {26'd0, 4'($urandom_range(8, 15)), 2'b00};
      d = $urandom;
      u = 1'($urandom_range(0, 1));
      drive_req(1, 2'b10, 0, a, d, 1, 0, 32'h0, a);
      drive_req(0, 2'b10, u, a, 32'h0, 1, 0, d, a);
    end

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    check_eq("drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    check_eq("watchdog", 0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Multi-cycle load/store controller. It is the initiator for the data memory port: it drives address, data_in, wr_en, mem_size and sz_ex, and samples data_out.
- Sits between the core's execute/memory stage and the data memory.
- Accepts one load/store request at a time over a valid/ready handshake and returns one response per request.

Parameters:
- BUS_WIDTH, 32, width of data and address buses.
- MEM_LATENCY, 1, cycles the memory port is driven before read data is sampled; legal values 1 to 7.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  2'b00 byte, 2'b01 half word, 2'b10 word, 2'b11 illegal.
- req_unsigned  in  1  load is zero-extended when 1, sign-extended when 0.
- req_addr  in  BUS_WIDTH  byte address.
- req_wdata  in  BUS_WIDTH  store data, right-justified.
- resp_valid  out  1  one-cycle response strobe.
- resp_rdata  out  BUS_WIDTH  load result, already extended by memory.
- resp_err  out  1  request rejected; no memory access performed.
- mem_address  out  BUS_WIDTH  memory byte address.
- mem_data_in  out  BUS_WIDTH  memory write data.
- mem_wr_en  out  1  memory write enable; memory writes on the rising clk edge.
- mem_size  out  2  memory access size, same encoding as req_size.
- mem_sz_ex  out  1  memory sign-extend select.
- mem_data_out  in  BUS_WIDTH  memory read data, combinational from the memory.

Behaviour:
- Clock: one clock, clk. Reset: rst is asynchronous and active-low.
- Reset values (rst low):
  - state IDLE; req_ready=1.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - mem_address=0, mem_data_in=0, mem_wr_en=0, mem_size=2'b10, mem_sz_ex=0.
  - Wait counter cleared.
- State IDLE:
  - req_ready=1 and mem_wr_en=0.
  - Request accepted on a rising edge with req_valid=1 and req_ready=1; all req_* fields are latched at that edge.
  - Illegal size, or misalignment when the optional feature is enabled: next state RESP with error.
  - Otherwise: next state ACCESS, counter loaded with MEM_LATENCY-1.
- State ACCESS:
  - req_ready=0.
  - mem_address, mem_size and mem_data_in come from latched values.
  - mem_sz_ex = ~unsigned for loads, 0 for stores.
  - mem_wr_en=1 only in the first ACCESS cycle of a store; it is never high for more than one cycle per request.
  - Counter decrements each cycle. When it reaches 0: loads capture mem_data_out into resp_rdata; next state RESP.
- State RESP:
  - resp_valid=1 for exactly one cycle; resp_err as decided at acceptance.
  - Stores and errors return resp_rdata=0.
  - Next state IDLE.
  - mem_* outputs hold their last value except mem_wr_en, which is 0.
- Latency:
  - Normal access: resp_valid is high in the cycle starting MEM_LATENCY+1 edges after the acceptance edge.
  - Error response: one edge after acceptance.
- Throughput: no back-to-back acceptance. req_ready is low from acceptance through RESP, so the minimum request spacing is MEM_LATENCY+2 cycles.
- Address: mem_address carries the full byte address; no lane shifting is done here (the memory handles size and extension).
- Reset mid-operation: rst low aborts immediately and asynchronously. mem_wr_en drops, no response is produced, and the pending request is lost. The core must re-issue it.
- req_valid is ignored outside IDLE; req fields may change freely after acceptance.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: half-word access with addr[0]=1, or word access with addr[1:0]!=0, is rejected. Response has resp_err=1 one cycle after acceptance, and memory is untouched.
- Undefined: misaligned addresses are forced aligned by clearing the low bits (addr[0] for half word, addr[1:0] for word). The access then proceeds normally with resp_err=0.
- Illegal size errors in both builds.

Decomposition:
- Shared define header holds: BUS_WIDTH, the size encodings WORD=2'b10, HALF_WORD=2'b01 and BYTE=2'b00, the illegal size 2'b11, and state encodings IDLE/ACCESS/RESP.
- One natural sub-module: lsu_align_check. It is combinational: takes size and addr, and produces misaligned, illegal and aligned_addr. Behaviour is selected by LSU_MISALIGN_TRAP_EN.

Test Plan:
1. Reset, then store word 32'h00FFFFFF to addr 8, followed by a signed load word from 8 -> store: mem_wr_en high exactly one cycle with mem_size=2'b10; load: resp_rdata=32'h00FFFFFF, resp_valid one cycle, MEM_LATENCY+1 cycles after acceptance.
2. Store byte 32'h0000FFFF to addr 4, followed by an unsigned half-word load from 4 -> resp_rdata=32'h000000FF; during load mem_sz_ex=0.
3. Store word 32'h000000FF to addr 0, followed by a signed byte load from 0 -> mem_sz_ex=1, resp_rdata=32'hFFFFFFFF.
4. Word load from addr 6 -> with LSU_MISALIGN_TRAP_EN: resp_err=1, resp_rdata=0, no mem_wr_en and state never enters ACCESS; without it: mem_address=4 and resp_err=0.
5. req_size=2'b11 store -> resp_err=1 one cycle after acceptance; mem_wr_en stays 0.
6. rst pulled low in the first ACCESS cycle of a store -> mem_wr_en falls immediately, no resp_valid, req_ready=1 after release; re-issued request completes normally.
